// File: rtl/iommu_reg_pkg.sv
// Shared types and helpers for the IOMMU register access front end.
package iommu_reg_pkg;

  // Write-merge state: IDLE, low half staged (HOLD), forced commit of the staged half (FLUSH).
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } state_e;

  localparam int REG_STRIDE = 8;  // bytes per 64-bit register
  localparam int HALF_BIT   = 2;  // address bit selecting the upper 32-bit half

  // Expand 4 byte enables into a 32-bit bit mask.
  function automatic logic [31:0] expand_be(input logic [3:0] be);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
    return m;
  endfunction

endpackage

// File: rtl/iommu_reg_access_ctrl.sv
// Bus-to-register-file front end: decodes 32-bit requests, merges low/high
// halves into atomic 64-bit writes, and issues one-cycle field strobes.
module iommu_reg_access_ctrl
  import iommu_reg_pkg::*;
#(
  parameter int AW      = 12,
  parameter int DW      = 32,
  parameter int NumRegs = 16,
  parameter int RegDW   = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic                     req_write_i,
  input  logic [AW-1:0]            req_addr_i,
  input  logic [DW-1:0]            req_wdata_i,
  input  logic [DW/8-1:0]          req_be_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [DW-1:0]            rsp_rdata_o,
  output logic                     rsp_error_o,
  input  logic [NumRegs*RegDW-1:0] reg_rdata_i,
  output logic [NumRegs-1:0]       reg_we_o,
  output logic [NumRegs-1:0]       reg_re_o,
  output logic [RegDW-1:0]         reg_wd_o,
  output logic [RegDW-1:0]         reg_wmask_o
);

  localparam int IdxLsb = $clog2(REG_STRIDE);
  localparam int IW     = AW - IdxLsb;
  localparam int HW     = (NumRegs > 1) ? $clog2(NumRegs) : 1;

  state_e              state, state_n;
  logic [IW-1:0]       idx;
  logic [HW-1:0]       hidx, hold_idx;
  logic                half, err, match, accept, stage_ld;
  logic [DW-1:0]       stage_lo, be_mask, rd_sel;
  logic [DW/8-1:0]     stage_be;
  logic [NumRegs-1:0]  req_oh, hold_oh, we_n, re_n;
  logic [RegDW-1:0]    wd_n, wmask_n;

  // Request decode
  assign idx     = req_addr_i[AW-1:IdxLsb];
  assign hidx    = idx[HW-1:0];
  assign half    = req_addr_i[HALF_BIT];
  assign err     = (req_addr_i[1:0] != 2'b00) || (idx >= IW'(NumRegs));
  assign be_mask = expand_be(req_be_i);
  assign req_oh  = NumRegs'(1) << hidx;
  assign hold_oh = NumRegs'(1) << hold_idx;
  assign rd_sel  = reg_rdata_i[int'(hidx)*RegDW + (half ? DW : 0) +: DW];

  // Only a write to either half of the staged register may proceed while holding.
  assign match   = req_write_i && !err && (hidx == hold_idx);

  assign req_ready_o = (state != FLUSH) && (!rsp_valid_o || rsp_ready_i) &&
                       !(state == HOLD && req_valid_i && !match);
  assign accept      = req_valid_i && req_ready_o;

  // Next state and next-cycle strobe values
  always_comb begin
    state_n  = state;
    stage_ld = 1'b0;
    we_n     = '0;
    re_n     = '0;
    wd_n     = '0;
    wmask_n  = '0;
    case (state)
      IDLE: begin
        if (accept && !err) begin
          if (!req_write_i) begin
            re_n = req_oh;
          end else if (!half) begin
            stage_ld = 1'b1;
            state_n  = HOLD;
          end else begin
            we_n    = req_oh;
            wd_n    = {req_wdata_i, {DW{1'b0}}};
            wmask_n = {be_mask, {DW{1'b0}}};
          end
        end
      end
      HOLD: begin
        if (req_valid_i && !match) begin
          // Commit the staged low half alone before letting the other request in.
          state_n = FLUSH;
          we_n    = hold_oh;
          wd_n    = {{DW{1'b0}}, stage_lo};
          wmask_n = {{DW{1'b0}}, expand_be(stage_be)};
        end else if (accept) begin
          if (half) begin
            state_n = IDLE;
            we_n    = hold_oh;
            wd_n    = {req_wdata_i, stage_lo};
            wmask_n = {be_mask, expand_be(stage_be)};
          end else begin
            stage_ld = 1'b1;
          end
        end
      end
      FLUSH:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State register and low-half staging
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      stage_lo <= '0;
      stage_be <= '0;
      hold_idx <= '0;
    end else begin
      state <= state_n;
      if (stage_ld) begin
        stage_lo <= req_wdata_i;
        stage_be <= req_be_i;
        hold_idx <= hidx;
      end
    end
  end

  // Registered one-cycle strobes toward the field write ports
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      reg_we_o    <= '0;
      reg_re_o    <= '0;
      reg_wd_o    <= '0;
      reg_wmask_o <= '0;
    end else begin
      reg_we_o    <= we_n;
      reg_re_o    <= re_n;
      reg_wd_o    <= wd_n;
      reg_wmask_o <= wmask_n;
    end
  end

  // Single-entry response register; read data captured in the accept cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_error_o <= 1'b0;
    end else if (accept) begin
      rsp_valid_o <= 1'b1;
      rsp_error_o <= err;
      rsp_rdata_o <= (!err && !req_write_i) ? rd_sel : '0;
    end else if (rsp_ready_i) begin
      rsp_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_iommu_reg_access_ctrl.sv
// Scoreboard bench for iommu_reg_access_ctrl with a transaction-level model.
module tb_iommu_reg_access_ctrl;
  localparam int NR = 16;

  typedef struct {
    logic [15:0] we;
    logic [15:0] re;
    logic [63:0] wd;
    logic [63:0] mask;
    int          cyc;
  } stb_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } rsp_t;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic          req_write_i = 1'b0;
  logic [11:0]   req_addr_i = '0;
  logic [31:0]   req_wdata_i = '0;
  logic [3:0]    req_be_i = '0;
  logic          rsp_valid_o;
  logic          rsp_ready_i = 1'b0;
  logic [31:0]   rsp_rdata_o;
  logic          rsp_error_o;
  logic [NR*64-1:0] reg_rdata;
  logic [NR-1:0] reg_we_o, reg_re_o;
  logic [63:0]   reg_wd_o, reg_wmask_o;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rr_mode = 0;  // 0: always ready, 1: random, 2: never ready
  bit load = 1'b1;

  stb_t sq[$];
  rsp_t rq[$];

  logic [63:0] hw_regs [NR];
  logic [63:0] seed    [NR];
  logic [63:0] mdl_regs[NR];
  bit          pend = 1'b0;
  int          pidx = 0;
  logic [31:0] plo = '0;
  logic [3:0]  pbe = '0;

  iommu_reg_access_ctrl dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_be_i(req_be_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_error_o(rsp_error_o), .reg_rdata_i(reg_rdata), .reg_we_o(reg_we_o),
    .reg_re_o(reg_re_o), .reg_wd_o(reg_wd_o), .reg_wmask_o(reg_wmask_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Simple register file behind the strobes
  always @(posedge clk)
    for (int i = 0; i < NR; i++)
      if (load) hw_regs[i] <= seed[i];
      else if (reg_we_o[i]) hw_regs[i] <= (hw_regs[i] & ~reg_wmask_o) | (reg_wd_o & reg_wmask_o);

  always_comb begin
    reg_rdata = '0;
    for (int i = 0; i < NR; i++) reg_rdata[i*64 +: 64] = hw_regs[i];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] bmask(input logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = be[i] ? 8'hFF : 8'h00;
    return m;
  endfunction

  function automatic bit is_err(input logic [11:0] a);
    return (a[1:0] != 2'b00) || (int'(a[11:3]) >= NR);
  endfunction

  task automatic mdl_commit(input int i, input logic [63:0] wd, input logic [63:0] m);
    stb_t e;
    mdl_regs[i] = (mdl_regs[i] & ~m) | (wd & m);
    e.we = 16'(1) << i; e.re = '0; e.wd = wd; e.mask = m; e.cyc = cyc + 1;
    sq.push_back(e);
  endtask

  // A request that cannot join the staged write forces the staged half out first.
  task automatic mdl_present(input logic w, input logic [11:0] a);
    if (pend && !(w && !is_err(a) && int'(a[11:3]) == pidx)) begin
      mdl_commit(pidx, {32'h0, plo}, {32'h0, bmask(pbe)});
      pend = 1'b0;
    end
  endtask

  task automatic mdl_accept(input logic w, input logic [11:0] a, input logic [31:0] d, input logic [3:0] be);
    rsp_t r;
    stb_t e;
    int ix;
    logic [63:0] cur;
    ix = int'(a[11:3]);
    r.rdata = '0; r.err = 1'b0; r.cyc = cyc + 1;
    if (is_err(a)) begin
      r.err = 1'b1;
    end else if (!w) begin
      cur = mdl_regs[ix];
      r.rdata = a[2] ? cur[63:32] : cur[31:0];
      e.we = '0; e.re = 16'(1) << ix; e.wd = '0; e.mask = '0; e.cyc = cyc + 1;
      sq.push_back(e);
    end else if (!a[2]) begin
      pend = 1'b1; pidx = ix; plo = d; pbe = be;
    end else if (pend) begin
      mdl_commit(ix, {d, plo}, {bmask(be), bmask(pbe)});
      pend = 1'b0;
    end else begin
      mdl_commit(ix, {d, 32'h0}, {bmask(be), 32'h0});
    end
    rq.push_back(r);
  endtask

  // Called at a falling edge; returns the cycle first presented and the cycle accepted.
  task automatic send(input logic w, input logic [11:0] a, input logic [31:0] d, input logic [3:0] be,
                      output int pres, output int acc);
    bit first, done;
    first = 1'b1; done = 1'b0; pres = -1; acc = -1;
    req_valid_i = 1'b1; req_write_i = w; req_addr_i = a; req_wdata_i = d; req_be_i = be;
    for (int k = 0; k < 64 && !done; k++) begin
      #2;
      if (first) begin pres = cyc; mdl_present(w, a); first = 1'b0; end
      if (req_ready_o) begin acc = cyc; mdl_accept(w, a, d, be); done = 1'b1; end
      @(negedge clk);
    end
    req_valid_i = 1'b0;
    if (!done) begin
      checks++; failures++;
      $display("FAIL accept_timeout addr=%h act=not_accepted exp=accepted", a);
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((sq.size() != 0 || rq.size() != 0 || rsp_valid_o) && k < 200) begin
      @(negedge clk); k++;
    end
    if (k >= 200) begin
      checks++; failures++;
      $display("FAIL drain_timeout act=%0d/%0d exp=0/0", sq.size(), rq.size());
    end
    @(negedge clk);
  endtask

  // Response-ready driver
  initial forever begin
    @(negedge clk); #1;
    case (rr_mode)
      0:       rsp_ready_i = 1'b1;
      1:       rsp_ready_i = ($urandom_range(0, 9) < 7);
      default: rsp_ready_i = 1'b0;
    endcase
  end

  // Monitor: pops expected strobes and responses as the DUT presents them
  initial begin
    bit ph;
    logic [31:0] prd;
    logic perr;
    stb_t e;
    rsp_t r;
    ph = 1'b0; prd = '0; perr = 1'b0;
    forever begin
      @(negedge clk); #3;
      if (!rst_ni) begin
        ph = 1'b0;
      end else begin
        if (reg_we_o != '0 || reg_re_o != '0) begin
          if (sq.size() == 0) begin
            checks++; failures++;
            $display("FAIL strobe_unexpected act=we:%h/re:%h exp=none", reg_we_o, reg_re_o);
          end else begin
            e = sq.pop_front();
            chk("strobe_cycle", 64'(cyc), 64'(e.cyc));
            chk("reg_we", 64'(reg_we_o), 64'(e.we));
            chk("reg_re", 64'(reg_re_o), 64'(e.re));
            chk("reg_wd", reg_wd_o, e.wd);
            chk("reg_wmask", reg_wmask_o, e.mask);
          end
        end
        if (ph) begin
          chk("rsp_hold_valid", 64'(rsp_valid_o), 64'(1));
          chk("rsp_hold_rdata", 64'(rsp_rdata_o), 64'(prd));
          chk("rsp_hold_error", 64'(rsp_error_o), 64'(perr));
        end else if (rsp_valid_o) begin
          if (rq.size() == 0) begin
            checks++; failures++;
            $display("FAIL rsp_unexpected act=valid exp=idle");
          end else begin
            r = rq.pop_front();
            chk("rsp_cycle", 64'(cyc), 64'(r.cyc));
            chk("rsp_rdata", 64'(rsp_rdata_o), 64'(r.rdata));
            chk("rsp_error", 64'(rsp_error_o), 64'(r.err));
          end
        end
        ph = rsp_valid_o && !rsp_ready_i;
        prd = rsp_rdata_o;
        perr = rsp_error_o;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int pr, ac, pa, rel;
    logic [8:0] ix;
    logic [1:0] lo;
    logic w;
    for (int i = 0; i < NR; i++) begin
      seed[i] = {$urandom, $urandom};
      mdl_regs[i] = seed[i];
    end
    rr_mode = 0;
    repeat (3) @(negedge clk);
    load = 1'b0;
    #1;
    chk("reset_rsp_valid", 64'(rsp_valid_o), 64'(0));
    chk("reset_rsp_rdata", 64'(rsp_rdata_o), 64'(0));
    chk("reset_rsp_error", 64'(rsp_error_o), 64'(0));
    chk("reset_reg_we", 64'(reg_we_o), 64'(0));
    chk("reset_reg_re", 64'(reg_re_o), 64'(0));
    chk("reset_reg_wd", reg_wd_o, 64'(0));
    chk("reset_reg_wmask", reg_wmask_o, 64'(0));
    @(negedge clk);
    rst_ni = 1'b1;
    #2 chk("ready_after_reset", 64'(req_ready_o), 64'(1));
    @(negedge clk);

    // Low then high half of register 1 merge into one commit
    send(1'b1, 12'h008, 32'h0000_0100, 4'hF, pr, ac);
    send(1'b1, 12'h00C, 32'h0000_0002, 4'hF, pr, ac);
    drain();

    // Staged write interrupted by a read of another register
    send(1'b1, 12'h010, 32'h0000_00AA, 4'hF, pr, ac);
    send(1'b0, 12'h018, 32'h0, 4'h0, pr, ac);
    chk("flush_ready_low_cycles", 64'(ac - pr), 64'(2));
    drain();

    // Unmapped and misaligned accesses
    send(1'b0, 12'h080, 32'h0, 4'h0, pr, ac);
    send(1'b1, 12'h006, 32'hDEAD_BEEF, 4'hF, pr, ac);
    drain();

    // Response backpressure for 5 cycles
    rr_mode = 2;
    send(1'b0, 12'h020, 32'h0, 4'h0, pr, ac);
    fork
      send(1'b0, 12'h02C, 32'h0, 4'h0, pr, ac);
      begin
        repeat (5) @(negedge clk);
        rr_mode = 0;
        rel = cyc;
      end
    join
    chk("backpressure_accept_cycle", 64'(ac), 64'(rel));
    drain();

    // Back-to-back high-half writes
    pa = 0;
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 12'(8 * (i + 6) + 4), $urandom, 4'(i + 9), pr, ac);
      if (i > 0) chk("b2b_accept_spacing", 64'(ac - pa), 64'(1));
      pa = ac;
    end
    drain();

    // Reset while a low half is staged and its response is held
    rr_mode = 2;
    send(1'b1, 12'h028, 32'h1234_5678, 4'hF, pr, ac);
    @(negedge clk);
    #2 rst_ni = 1'b0;
    #1;
    chk("midreset_rsp_valid", 64'(rsp_valid_o), 64'(0));
    chk("midreset_rsp_rdata", 64'(rsp_rdata_o), 64'(0));
    chk("midreset_reg_we", 64'(reg_we_o), 64'(0));
    pend = 1'b0;
    rr_mode = 0;
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    send(1'b1, 12'h02C, 32'hCAFE_0000, 4'hF, pr, ac);
    drain();

    // Randomized traffic
    rr_mode = 1;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) < 8) ix = 9'($urandom_range(0, 3));
      else ix = 9'($urandom_range(0, 17));
      lo = ($urandom_range(0, 14) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      w = ($urandom_range(0, 9) < 6);
      send(w, {ix, 1'($urandom_range(0, 1)), lo}, $urandom, 4'($urandom_range(0, 15)), pr, ac);
      if (w) @(negedge clk);
      if ($urandom_range(0, 4) == 0) @(negedge clk);
    end
    drain();
    chk("strobe_queue_empty", 64'(sq.size()), 64'(0));
    chk("rsp_queue_empty", 64'(rq.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
